// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
// Optional back-to-back forwarding is enabled by defining AXIS_ARB_B2B_EN.
package axis_arb_pkg;

    localparam int unsigned ARB_MAX_SRC = 8;

    typedef enum logic {
        StIdle,
        StSend
    } arb_state_e;

    // Tag width for a source index; never narrower than one bit.
    function automatic int unsigned src_w_calc(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module axis_rr_pick #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SRC_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);

    logic [SRC_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        idx        = '0;
        found      = 1'b0;
        any        = |req;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((32'(ptr) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-Stream sources into one tagged output register.
// Define AXIS_ARB_B2B_EN to accept a new word in the same cycle the held word leaves.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 2,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned SRC_W   = src_w_calc(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]        s_axis_valid,
    output logic [NUM_SRC-1:0]        s_axis_ready,
    output logic [DATA_W-1:0]         m_axis_data,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [SRC_W-1:0]          m_axis_src
);

    arb_state_e       state_q;
    logic [SRC_W-1:0] rr_ptr_q;
    logic [NUM_SRC-1:0] gnt_onehot;
    logic [SRC_W-1:0] gnt_idx;
    logic             any_req;
    logic [SRC_W-1:0] ptr_next;
    logic [DATA_W-1:0] win_data;

    axis_rr_pick #(
        .NUM_SRC(NUM_SRC),
        .SRC_W  (SRC_W)
    ) u_pick (
        .req       (s_axis_valid),
        .ptr       (rr_ptr_q),
        .gnt_onehot(gnt_onehot),
        .gnt_idx   (gnt_idx),
        .any       (any_req)
    );

    always_comb begin
        ptr_next = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        win_data = s_axis_data[32'(gnt_idx)*DATA_W +: DATA_W];
    end

    // gnt_onehot is zero when nothing requests, so it doubles as the ready vector.
    always_comb begin
        s_axis_ready = '0;
        if (!rst) begin
            unique case (state_q)
                StIdle: s_axis_ready = gnt_onehot;
`ifdef AXIS_ARB_B2B_EN
                StSend: s_axis_ready = m_axis_ready ? gnt_onehot : '0;
`else
                StSend: s_axis_ready = '0;
`endif
                default: s_axis_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_src   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        m_axis_data  <= win_data;
                        m_axis_src   <= gnt_idx;
                        m_axis_valid <= 1'b1;
                        rr_ptr_q     <= ptr_next;
                        state_q      <= StSend;
                    end
                end
                StSend: begin
                    if (m_axis_ready) begin
`ifdef AXIS_ARB_B2B_EN
                        if (any_req) begin
                            m_axis_data <= win_data;
                            m_axis_src  <= gnt_idx;
                            rr_ptr_q    <= ptr_next;
                        end else begin
                            m_axis_valid <= 1'b0;
                            state_q      <= StIdle;
                        end
`else
                        m_axis_valid <= 1'b0;
                        state_q      <= StIdle;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised scoreboard bench for axis_rr_arbiter with a 4-source reference model.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] s_axis_data;
    logic [N-1:0]  s_axis_valid;
    logic [N-1:0]  s_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [1:0]    m_axis_src;

    axis_rr_arbiter #(
        .NUM_SRC(N),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_data (s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_src  (m_axis_src)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected words in delivery order: {src, data}.
    logic [17:0] exp_q[$];

    // Reference model state.
    bit mdl_valid = 1'b0;
    int mdl_ptr   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input logic [N-1:0] v, input bit mr,
                        input logic [N*DW-1:0] d);
        int w;
        logic [N-1:0] exp_rdy;
        bit take;
        @(negedge clk);
        rst          = r;
        s_axis_valid = v;
        m_axis_ready = mr;
        s_axis_data  = d;
        #1;
        w       = pick(v, mdl_ptr);
        exp_rdy = '0;
        take    = 1'b0;
        if (!r) begin
`ifdef AXIS_ARB_B2B_EN
            take = (w >= 0) && (!mdl_valid || mr);
`else
            take = (w >= 0) && !mdl_valid;
`endif
            if (take) exp_rdy[w] = 1'b1;
        end
        chk("s_axis_ready", 64'(s_axis_ready), 64'(exp_rdy));
        chk("m_axis_valid", 64'(m_axis_valid), 64'(mdl_valid));
        if (r) begin
            exp_q.delete();
            mdl_valid = 1'b0;
            mdl_ptr   = 0;
        end else if (take) begin
            exp_q.push_back({2'(w), d[w*DW +: DW]});
            mdl_valid = 1'b1;
            mdl_ptr   = (w + 1) % N;
        end else if (mdl_valid && mr) begin
            mdl_valid = 1'b0;
        end
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Monitor: pops on every downstream handshake and checks held words stay stable.
    initial begin : monitor
        logic [17:0] e;
        bit          hold_prev = 1'b0;
        logic [17:0] held;
        forever begin
            @(negedge clk);
            #2;
            if (hold_prev) begin
                chk("hold_valid", 64'(m_axis_valid), 64'd1);
                chk("hold_word", 64'({m_axis_src, m_axis_data}), 64'(held));
            end
            if (!rst && m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'({m_axis_src, m_axis_data}), 64'h3_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_axis_src", 64'(m_axis_src), 64'(e[17:16]));
                    chk("m_axis_data", 64'(m_axis_data), 64'(e[15:0]));
                end
            end
            hold_prev = !rst && m_axis_valid && !m_axis_ready;
            held      = {m_axis_src, m_axis_data};
        end
    end

    initial begin : driver
        logic [N*DW-1:0] d;
        rst          = 1'b1;
        s_axis_valid = '0;
        s_axis_data  = '0;
        m_axis_ready = 1'b0;
        repeat (3) step(1'b1, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, '0);
        chk("reset_data", 64'(m_axis_data), 64'd0);
        chk("reset_src", 64'(m_axis_src), 64'd0);

        // Single source word.
        d = rnd_data();
        d[DW-1:0] = 16'h1234;
        step(1'b0, 4'b0001, 1'b1, d);
        repeat (3) step(1'b0, '0, 1'b1, '0);

        // All sources contending, receiver always ready.
        repeat (16) step(1'b0, 4'b1111, 1'b1, rnd_data());

        // Long back-pressure with requests pending.
        repeat (30) step(1'b0, 4'($urandom), 1'b0, rnd_data());
        repeat (4) step(1'b0, '0, 1'b1, '0);

        // Wrap-around: src3 then src0.
        step(1'b0, 4'b1000, 1'b1, rnd_data());
        step(1'b0, 4'b0000, 1'b1, rnd_data());
        step(1'b0, 4'b0001, 1'b1, rnd_data());
        repeat (2) step(1'b0, '0, 1'b1, '0);

        // Reset while a word is held.
        d = rnd_data();
        d[2*DW +: DW] = 16'hBEEF;
        step(1'b0, 4'b0100, 1'b0, d);
        step(1'b0, '0, 1'b0, '0);
        step(1'b1, '0, 1'b1, '0);
        repeat (3) step(1'b0, '0, 1'b1, '0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                 rnd_data());
        end

        repeat (6) step(1'b0, '0, 1'b1, '0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
